tx_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one Avalon-ST 32-bit Ethernet TX stream between N_SRC packet generators (ARP sender, BFD sender, test generators). It sits between the generators and the MAC TX FIFO. A grant is held from startofpacket to endofpacket, so frames are never interleaved. The output is registered through a 2-entry skid buffer, and per-source sent-packet counters are exported for the CSR block.

---
 rtl/pkt_arb_pkg.sv | 41 ++++
 rtl/tx_pkt_arbiter_if.sv | 36 +++
 rtl/st_skid_buf.sv | 80 ++++++++
 rtl/tx_pkt_arbiter.sv | 127 ++++++++++++
 tb/tb_tx_pkt_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types for the TX packet arbiter: FSM states, Avalon-ST beat record
// and the round-robin pick helper.
package pkt_arb_pkg;

    localparam int MAX_SRC    = 8;
    localparam int ST_DATA_W  = 32;
    localparam int ST_EMPTY_W = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ST_DATA_W-1:0]  data;
        logic                  sop;
        logic                  eop;
        logic [ST_EMPTY_W-1:0] empty;
    } beat_t;

    // First set bit of mask searching upward from last+1, wrapping at n.
    // Returns last when mask is empty.
    function automatic logic [2:0] rr_next(input logic [MAX_SRC-1:0] mask,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = 3'((int'(last) + k) % n);
            if (k <= n && !found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tx_pkt_arbiter_if.sv
// Avalon-ST bundle around the arbiter: N_SRC generator sinks plus the merged source.
// master = generators/MAC side, slave = arbiter.
interface tx_pkt_arbiter_if #(
    parameter int N_SRC  = 2,
    parameter int DATA_W = 32
) ();
    localparam int EMPTY_W = $clog2(DATA_W/8);

    logic [N_SRC-1:0]         asi_snk_valid;
    logic [N_SRC*DATA_W-1:0]  asi_snk_data;
    logic [N_SRC-1:0]         asi_snk_startofpacket;
    logic [N_SRC-1:0]         asi_snk_endofpacket;
    logic [N_SRC*EMPTY_W-1:0] asi_snk_empty;
    logic [N_SRC-1:0]         asi_snk_ready;

    logic                     aso_src0_ready;
    logic [DATA_W-1:0]        aso_src0_data;
    logic                     aso_src0_valid;
    logic                     aso_src0_startofpacket;
    logic                     aso_src0_endofpacket;
    logic [EMPTY_W-1:0]       aso_src0_empty;

    modport master (
        output asi_snk_valid, asi_snk_data, asi_snk_startofpacket,
               asi_snk_endofpacket, asi_snk_empty, aso_src0_ready,
        input  asi_snk_ready, aso_src0_data, aso_src0_valid,
               aso_src0_startofpacket, aso_src0_endofpacket, aso_src0_empty
    );

    modport slave (
        input  asi_snk_valid, asi_snk_data, asi_snk_startofpacket,
               asi_snk_endofpacket, asi_snk_empty, aso_src0_ready,
        output asi_snk_ready, aso_src0_data, aso_src0_valid,
               aso_src0_startofpacket, aso_src0_endofpacket, aso_src0_empty
    );
endinterface

// File: rtl/st_skid_buf.sv
// 2-entry Avalon-ST register slice; 1-cycle latency when empty, outputs straight from flops.
// in_rdy is a registered not-full flag, so upstream never sees a combinational path from out_rdy.
module st_skid_buf #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty
);
    localparam int BEAT_W = DATA_W + 2 + EMPTY_W;

    logic [BEAT_W-1:0] in_beat, head_q, head_d, skid_q, skid_d;
    logic [1:0]        count_q, count_d;
    logic              rdy_q, rdy_d, vld_q, vld_d;
    logic              push, pop;

    assign in_beat = {in_data, in_sop, in_eop, in_empty};
    assign push    = in_vld & rdy_q;
    assign pop     = vld_q & out_rdy;

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (count_q)
            2'd0: if (push) begin
                head_d  = in_beat;
                count_d = 2'd1;
            end
            2'd1: case ({push, pop})
                2'b11: head_d = in_beat;
                2'b10: begin
                    skid_d  = in_beat;
                    count_d = 2'd2;
                end
                2'b01: count_d = 2'd0;
                default: ;
            endcase
            2'd2: if (pop) begin
                head_d  = skid_q;
                count_d = 2'd1;
            end
            default: count_d = 2'd0;
        endcase
        rdy_d = (count_d != 2'd2);
        vld_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    assign in_rdy  = rdy_q;
    assign out_vld = vld_q;
    assign {out_data, out_sop, out_eop, out_empty} = head_q;
endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin merge of N_SRC Avalon-ST generators onto one TX stream.
// Sink-to-source latency 1 cycle; 1 idle arbitration cycle per packet; sink ready follows skid-buffer not-full.
module tx_pkt_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int  N_SRC   = 2,
    parameter int  DATA_W  = 32,
    parameter int  CNT_W   = 16,
    localparam int EMPTY_W = $clog2(DATA_W/8),
    localparam int GIDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   csi_clock_clk,
    input  logic                   csi_clock_reset,
    input  logic [N_SRC-1:0]       src_enable,
    tx_pkt_arbiter_if.slave        st,
    output logic [GIDX_W-1:0]      grant_idx,
    output logic                   busy,
    output logic                   err_stray,
    output logic [N_SRC*CNT_W-1:0] stat_pkt_cnt
);
    arb_state_e                  state_q, state_d;
    logic [GIDX_W-1:0]           grant_idx_q, grant_idx_d;
    logic [N_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        err_stray_q, err_stray_d;

    logic [N_SRC-1:0]   req, stray, snk_rdy;
    logic [MAX_SRC-1:0] req_ext;
    logic               sel_vld, sel_sop, sel_eop;
    logic [DATA_W-1:0]  sel_data;
    logic [EMPTY_W-1:0] sel_empty;
    logic               buf_in_rdy, push;

    assign req   = st.asi_snk_valid &  st.asi_snk_startofpacket & src_enable;
    assign stray = st.asi_snk_valid & ~st.asi_snk_startofpacket & src_enable;

    always_comb begin
        sel_vld   = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        sel_empty = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_idx_q == GIDX_W'(i)) begin
                sel_vld   = st.asi_snk_valid[i];
                sel_sop   = st.asi_snk_startofpacket[i];
                sel_eop   = st.asi_snk_endofpacket[i];
                sel_data  = st.asi_snk_data[i*DATA_W +: DATA_W];
                sel_empty = st.asi_snk_empty[i*EMPTY_W +: EMPTY_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        cnt_d       = cnt_q;
        err_stray_d = 1'b0;
        snk_rdy     = '0;
        push        = 1'b0;
        req_ext     = '0;
        req_ext[N_SRC-1:0] = req;
        case (state_q)
            IDLE: begin
                // A stray beat blocks every grant this cycle; it is swallowed and flagged.
                if (|stray) begin
                    snk_rdy     = stray;
                    err_stray_d = 1'b1;
                end else if (|req) begin
                    grant_idx_d = GIDX_W'(rr_next(req_ext, 3'(grant_idx_q), N_SRC));
                    state_d     = LOCKED;
                end
            end
            LOCKED: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (grant_idx_q == GIDX_W'(i)) snk_rdy[i] = buf_in_rdy;
                end
                push = sel_vld & buf_in_rdy;
                if (push && sel_eop) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (grant_idx_q == GIDX_W'(i)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge csi_clock_clk) begin
        if (csi_clock_reset) begin
            state_q     <= IDLE;
            grant_idx_q <= GIDX_W'(N_SRC - 1);
            cnt_q       <= '0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            cnt_q       <= cnt_d;
            err_stray_q <= err_stray_d;
        end
    end

    st_skid_buf #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W)
    ) u_skid (
        .clk       (csi_clock_clk),
        .rst       (csi_clock_reset),
        .in_vld    (push),
        .in_rdy    (buf_in_rdy),
        .in_data   (sel_data),
        .in_sop    (sel_sop),
        .in_eop    (sel_eop),
        .in_empty  (sel_empty),
        .out_vld   (st.aso_src0_valid),
        .out_rdy   (st.aso_src0_ready),
        .out_data  (st.aso_src0_data),
        .out_sop   (st.aso_src0_startofpacket),
        .out_eop   (st.aso_src0_endofpacket),
        .out_empty (st.aso_src0_empty)
    );

    assign st.asi_snk_ready = csi_clock_reset ? '0 : snk_rdy;
    assign grant_idx        = grant_idx_q;
    assign busy             = (state_q == LOCKED);
    assign err_stray        = err_stray_q;
    assign stat_pkt_cnt     = cnt_q;
endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed bench for tx_pkt_arbiter: per-source beat queues feed the sinks,
// the merged stream is captured and compared against hand-ordered expected frames.
module tb_tx_pkt_arbiter;
    import pkt_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_enable;
    logic [0:0]  grant_idx;
    logic        busy, err_stray;
    logic [31:0] stat_pkt_cnt;

    always #5 clk = ~clk;

    tx_pkt_arbiter_if #(.N_SRC(2), .DATA_W(32)) st ();

    tx_pkt_arbiter #(.N_SRC(2), .DATA_W(32), .CNT_W(16)) dut (
        .csi_clock_clk   (clk),
        .csi_clock_reset (rst),
        .src_enable      (src_enable),
        .st              (st),
        .grant_idx       (grant_idx),
        .busy            (busy),
        .err_stray       (err_stray),
        .stat_pkt_cnt    (stat_pkt_cnt)
    );

    beat_t sq0[$], sq1[$], mon[$], exp_q[$];
    int    n_chk = 0, n_pass = 0;
    int    sent0 = 0, sent1 = 0, errcnt = 0, cyc = 0;
    bit    pat_en = 1'b0, stab_en = 1'b0, prev_stall = 1'b0;
    logic [3:0]  pat = 4'b1001;
    logic        s_out_vld, s_busy, s_err;
    logic [0:0]  s_grant;
    logic [1:0]  s_snk_rdy;
    logic [15:0] s_cnt0, s_cnt1;
    logic [63:0] s_out, prev_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        beat_t b;
        st.asi_snk_valid         = '0;
        st.asi_snk_data          = '0;
        st.asi_snk_startofpacket = '0;
        st.asi_snk_endofpacket   = '0;
        st.asi_snk_empty         = '0;
        if (sq0.size() > 0) begin
            b = sq0[0];
            st.asi_snk_valid[0]         = 1'b1;
            st.asi_snk_data[31:0]       = b.data;
            st.asi_snk_startofpacket[0] = b.sop;
            st.asi_snk_endofpacket[0]   = b.eop;
            st.asi_snk_empty[1:0]       = b.empty;
        end
        if (sq1.size() > 0) begin
            b = sq1[0];
            st.asi_snk_valid[1]         = 1'b1;
            st.asi_snk_data[63:32]      = b.data;
            st.asi_snk_startofpacket[1] = b.sop;
            st.asi_snk_endofpacket[1]   = b.eop;
            st.asi_snk_empty[3:2]       = b.empty;
        end
        st.aso_src0_ready = pat_en ? pat[cyc % 4] : 1'b1;
    endtask

    // One clock: sample everything at the falling edge, then present next inputs after the rising edge.
    task automatic step();
        beat_t m;
        @(negedge clk);
        s_out     = 64'({st.aso_src0_valid, st.aso_src0_data, st.aso_src0_startofpacket,
                         st.aso_src0_endofpacket, st.aso_src0_empty});
        s_out_vld = st.aso_src0_valid;
        s_busy    = busy;
        s_err     = err_stray;
        s_grant   = grant_idx;
        s_snk_rdy = st.asi_snk_ready;
        s_cnt0    = stat_pkt_cnt[15:0];
        s_cnt1    = stat_pkt_cnt[31:16];
        if (stab_en && prev_stall) chk("stall_stable", s_out, prev_out);
        prev_stall = st.aso_src0_valid && !st.aso_src0_ready;
        prev_out   = s_out;
        if (st.aso_src0_valid && st.aso_src0_ready) begin
            m.data  = st.aso_src0_data;
            m.sop   = st.aso_src0_startofpacket;
            m.eop   = st.aso_src0_endofpacket;
            m.empty = st.aso_src0_empty;
            mon.push_back(m);
        end
        if (st.asi_snk_valid[0] && st.asi_snk_ready[0]) begin
            void'(sq0.pop_front());
            sent0++;
        end
        if (st.asi_snk_valid[1] && st.asi_snk_ready[1]) begin
            void'(sq1.pop_front());
            sent1++;
        end
        if (err_stray) errcnt++;
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic add_frame(input int src, input int fid, input int n, input bit expect_it);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data  = {8'(src), 8'(fid), 16'(k)};
            b.sop   = (k == 0);
            b.eop   = (k == n - 1);
            b.empty = (k == n - 1) ? 2'(fid) : 2'b00;
            if (src == 0) sq0.push_back(b);
            else          sq1.push_back(b);
            if (expect_it) exp_q.push_back(b);
        end
    endtask

    task automatic check_stream(input string tag);
        int mism;
        mism = 0;
        chk({tag, "_len"}, 64'(mon.size()), 64'(exp_q.size()));
        for (int i = 0; i < mon.size() && i < exp_q.size(); i++)
            if (mon[i] !== exp_q[i]) mism++;
        chk({tag, "_beats"}, 64'(mism), 64'd0);
        mon.delete();
        exp_q.delete();
    endtask

    task automatic run_quiet(input string tag, input int budget, input bit incl0);
        int k;
        bit pend;
        k    = 0;
        pend = 1'b1;
        while (pend && k < budget) begin
            step();
            k++;
            pend = (incl0 && sq0.size() != 0) || sq1.size() != 0 || s_busy || s_out_vld;
        end
        chk({tag, "_drained"}, 64'(pend), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    lat;
        int    k;
        beat_t sb;

        rst        = 1'b1;
        src_enable = 2'b11;
        @(posedge clk);
        #1;
        drive();
        step();
        step();
        chk("rst_out",   s_out,            64'd0);
        chk("rst_rdy",   64'(s_snk_rdy),   64'd0);
        chk("rst_grant", 64'(s_grant),     64'd1);
        chk("rst_busy",  64'(s_busy),      64'd0);
        chk("rst_err",   64'(s_err),       64'd0);
        chk("rst_cnt",   {s_cnt1, s_cnt0}, 64'd0);

        // Simultaneous 11-beat frames right after reset
        rst = 1'b0;
        add_frame(0, 1, 11, 1'b1);
        add_frame(1, 1, 11, 1'b1);
        drive();
        lat = 0;
        step();
        while (!s_out_vld && lat < 20) begin
            lat++;
            step();
        end
        chk("t1_latency", 64'(lat), 64'd2);
        run_quiet("t1", 200, 1'b1);
        check_stream("t1");
        chk("t1_cnt0", 64'(s_cnt0), 64'd1);
        chk("t1_cnt1", 64'(s_cnt1), 64'd1);

        // Six back-to-back frames, grant must alternate starting at source 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int f = 2; f <= 4; f++) begin
            add_frame(0, f, 3 + f, 1'b1);
            add_frame(1, f, 2 + f, 1'b1);
        end
        drive();
        run_quiet("t2", 400, 1'b1);
        check_stream("t2");
        chk("t2_cnt0", 64'(s_cnt0), 64'd3);
        chk("t2_cnt1", 64'(s_cnt1), 64'd3);

        // Downstream ready pattern 1,0,0,1 across a whole frame
        pat_en     = 1'b1;
        stab_en    = 1'b1;
        prev_stall = 1'b0;
        add_frame(0, 5, 9, 1'b1);
        drive();
        run_quiet("t3", 400, 1'b1);
        pat_en  = 1'b0;
        stab_en = 1'b0;
        check_stream("t3");
        chk("t3_cnt0", 64'(s_cnt0), 64'd4);

        // Stray beat on source 1 alongside a real SOP on source 0
        errcnt   = 0;
        sb.data  = 32'hDEADBEEF;
        sb.sop   = 1'b0;
        sb.eop   = 1'b0;
        sb.empty = 2'b00;
        sq1.push_back(sb);
        add_frame(0, 6, 4, 1'b1);
        drive();
        step();
        chk("t4_stray_rdy", 64'(s_snk_rdy), 64'd2);
        chk("t4_c0_busy",   64'(s_busy),    64'd0);
        step();
        chk("t4_err_pulse", 64'(s_err),     64'd1);
        chk("t4_nogrant",   64'(s_busy),    64'd0);
        chk("t4_c1_rdy",    64'(s_snk_rdy), 64'd0);
        run_quiet("t4", 200, 1'b1);
        chk("t4_err_count", 64'(errcnt), 64'd1);
        check_stream("t4");
        chk("t4_cnt0", 64'(s_cnt0), 64'd5);

        // Disable source 0 mid-frame: frame completes, then source 0 is skipped
        add_frame(0, 7, 8, 1'b1);
        add_frame(0, 8, 4, 1'b0);
        drive();
        sent0 = 0;
        k     = 0;
        while (sent0 < 3 && k < 50) begin
            step();
            k++;
        end
        chk("t5_three_beats", 64'(sent0), 64'd3);
        src_enable = 2'b10;
        add_frame(1, 7, 5, 1'b1);
        drive();
        run_quiet("t5", 300, 1'b0);
        repeat (3) step();
        chk("t5_skip_busy",  64'(s_busy),     64'd0);
        chk("t5_skip_rdy",   64'(s_snk_rdy),  64'd0);
        chk("t5_grant",      64'(s_grant),    64'd1);
        chk("t5_sq0_left",   64'(sq0.size()), 64'd4);
        check_stream("t5");
        chk("t5_cnt0", 64'(s_cnt0), 64'd6);
        chk("t5_cnt1", 64'(s_cnt1), 64'd4);

        // One-cycle reset in the middle of a source 1 frame
        src_enable = 2'b11;
        sq0.delete();
        add_frame(1, 8, 11, 1'b0);
        drive();
        sent1 = 0;
        k     = 0;
        while (sent1 < 5 && k < 50) begin
            step();
            k++;
        end
        chk("t6_mid_frame", 64'(sent1), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sq0.delete();
        sq1.delete();
        mon.delete();
        exp_q.delete();
        add_frame(0, 9, 3, 1'b1);
        add_frame(1, 9, 3, 1'b1);
        drive();
        step();
        chk("t6_post_vld",   64'(s_out_vld),    64'd0);
        chk("t6_post_busy",  64'(s_busy),       64'd0);
        chk("t6_post_cnt",   {s_cnt1, s_cnt0},  64'd0);
        chk("t6_post_grant", 64'(s_grant),      64'd1);
        step();
        chk("t6_grant0", 64'(s_grant), 64'd0);
        chk("t6_busy",   64'(s_busy),  64'd1);
        run_quiet("t6", 200, 1'b1);
        check_stream("t6");
        chk("t6_cnt0", 64'(s_cnt0), 64'd1);
        chk("t6_cnt1", 64'(s_cnt1), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
